// File: rtl/rs_encoder_stream_pkg.sv
// Shared constants, state encoding and GF(2^8) helpers for the RS(255,239) encoder.
// The generator coefficients are derived at elaboration from PRIM_POLY and FCR.
package rs_pkg;

    localparam int         RS_N         = 255;
    localparam int         RS_K         = 239;
    localparam int         RS_NPAR      = 16;
    localparam int         RS_FCR       = 0;
    localparam logic [8:0] RS_PRIM_POLY = 9'h11D;

    typedef enum logic {
        ST_MSG = 1'b0,
        ST_PAR = 1'b1
    } rs_state_e;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? RS_PRIM_POLY[7:0] : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = gf_xtime(sh);
        end
        return acc;
    endfunction

    // g(x) = prod (x + alpha^(FCR+i)), i = 0..NPAR-1; the monic x^16 term is implicit.
    function automatic logic [RS_NPAR-1:0][7:0] rs_gen_poly();
        logic [RS_NPAR:0][7:0] poly;
        logic [7:0]            root;
        poly    = '0;
        poly[0] = 8'h01;
        root    = 8'h01;
        for (int i = 0; i < RS_FCR; i++) root = gf_xtime(root);
        for (int i = 0; i < RS_NPAR; i++) begin
            for (int j = RS_NPAR; j >= 1; j--) poly[j] = poly[j-1] ^ gf_mul(poly[j], root);
            poly[0] = gf_mul(poly[0], root);
            root    = gf_xtime(root);
        end
        return poly[RS_NPAR-1:0];
    endfunction

    localparam logic [RS_NPAR-1:0][7:0] RS_G = rs_gen_poly();

endpackage

// File: rtl/rs_encoder_stream_if.sv
// Streaming bus of the RS encoder: message symbols in, codeword symbols out.
interface rs_encoder_stream_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sop;
    logic       out_eop;
    logic       out_parity;
    logic       cw_done;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop, out_parity, cw_done
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop, out_parity, cw_done
    );
endinterface

// File: rtl/rs_encoder_stream_gf_mul_const.sv
// Constant-by-variable GF(2^8) multiplier; with C fixed this folds to an XOR network.
module gf_mul_const
    import rs_pkg::*;
#(
    parameter logic [7:0] C = 8'h01
) (
    input  logic [7:0] i_a,
    output logic [7:0] o_p
);
    assign o_p = gf_mul(C, i_a);
endmodule

// File: rtl/rs_encoder_stream.sv
// Systematic RS(255,239) encoder: passes message symbols through, then appends 16 parity.
//   state  | meaning
//   ST_MSG | accepting message symbols, LFSR divides by g(x)
//   ST_PAR | shifting the 16 parity symbols out of the LFSR, input stalled
module rs_encoder_stream
    import rs_pkg::*;
(
    input logic                clk,
    input logic                reset,
    rs_encoder_stream_if.slave bus
);
    rs_state_e               r_state, w_state_nxt;
    logic [RS_NPAR-1:0][7:0] r_p, w_p_nxt;
    logic [7:0]              r_sym_cnt, w_sym_cnt_nxt;
    logic [3:0]              r_par_cnt, w_par_cnt_nxt;
    logic                    r_out_valid, w_out_valid_nxt;
    logic [7:0]              r_out_data, w_out_data_nxt;
    logic                    r_out_sop, w_out_sop_nxt;
    logic                    r_out_eop, w_out_eop_nxt;
    logic                    r_out_parity, w_out_parity_nxt;
    logic                    r_cw_done, w_cw_done_nxt;
    logic                    w_out_free;
    logic                    w_in_ready;
    logic [7:0]              w_fb;
    logic [7:0]              w_gfb [RS_NPAR];

    assign w_out_free = !r_out_valid || bus.out_ready;
    assign w_fb       = bus.in_data ^ r_p[RS_NPAR-1];

    for (genvar gi = 0; gi < RS_NPAR; gi++) begin : g_mul
        gf_mul_const #(.C(RS_G[gi])) u_mul (
            .i_a (w_fb),
            .o_p (w_gfb[gi])
        );
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_p_nxt          = r_p;
        w_sym_cnt_nxt    = r_sym_cnt;
        w_par_cnt_nxt    = r_par_cnt;
        w_out_valid_nxt  = r_out_valid && !bus.out_ready;
        w_out_data_nxt   = r_out_data;
        w_out_sop_nxt    = r_out_sop;
        w_out_eop_nxt    = r_out_eop;
        w_out_parity_nxt = r_out_parity;
        w_cw_done_nxt    = r_out_valid && bus.out_ready && r_out_eop;
        w_in_ready       = 1'b0;

        unique case (r_state)
            ST_MSG: begin
                w_in_ready = w_out_free;
                if (bus.in_valid && w_out_free) begin
                    w_out_data_nxt   = bus.in_data;
                    w_out_valid_nxt  = 1'b1;
                    w_out_sop_nxt    = (r_sym_cnt == 8'd0);
                    w_out_eop_nxt    = 1'b0;
                    w_out_parity_nxt = 1'b0;
                    w_p_nxt[0]       = w_gfb[0];
                    for (int i = 1; i < RS_NPAR; i++) w_p_nxt[i] = r_p[i-1] ^ w_gfb[i];
                    w_sym_cnt_nxt    = r_sym_cnt + 8'd1;
                    // Length is capped at K regardless of in_last.
                    if (bus.in_last || r_sym_cnt == 8'(RS_K - 1)) begin
                        w_state_nxt   = ST_PAR;
                        w_par_cnt_nxt = 4'd0;
                    end
                end
            end
            ST_PAR: begin
                if (w_out_free) begin
                    w_out_data_nxt   = r_p[RS_NPAR-1];
                    w_out_valid_nxt  = 1'b1;
                    w_out_sop_nxt    = 1'b0;
                    w_out_parity_nxt = 1'b1;
                    w_out_eop_nxt    = (r_par_cnt == 4'(RS_NPAR - 1));
                    w_p_nxt          = {r_p[RS_NPAR-2:0], 8'h00};
                    w_par_cnt_nxt    = r_par_cnt + 4'd1;
                    if (r_par_cnt == 4'(RS_NPAR - 1)) begin
                        w_state_nxt   = ST_MSG;
                        w_sym_cnt_nxt = 8'd0;
                    end
                end
            end
            default: w_state_nxt = ST_MSG;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_MSG;
            r_p          <= '0;
            r_sym_cnt    <= 8'd0;
            r_par_cnt    <= 4'd0;
            r_out_valid  <= 1'b0;
            r_out_data   <= 8'h00;
            r_out_sop    <= 1'b0;
            r_out_eop    <= 1'b0;
            r_out_parity <= 1'b0;
            r_cw_done    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_p          <= w_p_nxt;
            r_sym_cnt    <= w_sym_cnt_nxt;
            r_par_cnt    <= w_par_cnt_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_sop    <= w_out_sop_nxt;
            r_out_eop    <= w_out_eop_nxt;
            r_out_parity <= w_out_parity_nxt;
            r_cw_done    <= w_cw_done_nxt;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_sop    = r_out_sop;
    assign bus.out_eop    = r_out_eop;
    assign bus.out_parity = r_out_parity;
    assign bus.cw_done    = r_cw_done;

endmodule

// File: tb/tb_rs_encoder_stream.sv
// Self-checking bench for rs_encoder_stream: scoreboard of expected codeword symbols,
// syndrome evaluation of every completed codeword, and directed boundary scenarios.
module tb_rs_encoder_stream;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rs_encoder_stream_if bus();

    rs_encoder_stream dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       par;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] cap[$];
    logic [7:0] capa[$];
    logic [7:0] cwbuf[$];
    logic [7:0] alog [256];
    int         lg   [256];
    logic [7:0] gen  [16];
    logic [7:0] rem  [16];
    logic [7:0] msg  [239];
    logic [7:0] p_short [16];

    int n_checks = 0;
    int n_errors = 0;
    int m_cnt = 0, cw_cnt = 0, cyc = 0, sop_cyc = 0, eop_cyc = 0, last_gap = -1, par_seen = 0;
    bit exp_par = 1'b0, cw_pend = 1'b0, have_eop = 1'b0, bp_mode = 1'b0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return alog[(lg[a] + lg[b]) % 255];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) begin
        #1;
        bus.out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: compare transfers against the scoreboard, push expectations on accept.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] s;
        logic [7:0] fb;
        int         bad;
        cyc++;
        if (!reset) begin
            sb.delete();
            cwbuf.delete();
            for (int i = 0; i < 16; i++) rem[i] = 8'h00;
            m_cnt    = 0;
            exp_par  = 1'b0;
            cw_pend  = 1'b0;
            par_seen = 0;
            have_eop = 1'b0;
        end else begin
            chk("cw_done", {31'd0, bus.cw_done}, {31'd0, cw_pend});
            if (bus.cw_done) cw_cnt++;
            cw_pend = bus.out_valid && bus.out_ready && bus.out_eop;
            if (bus.out_valid && bus.out_eop) exp_par = 1'b0;
            if (exp_par) chk("in_ready_in_parity", {31'd0, bus.in_ready}, 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_sym", {21'd0, bus.out_data, bus.out_sop, bus.out_eop, bus.out_parity},
                        {21'd0, e});
                end
                cap.push_back(bus.out_data);
                if (bus.out_sop) begin
                    cwbuf.delete();
                    par_seen = 0;
                    if (have_eop) last_gap = cyc - eop_cyc;
                    sop_cyc = cyc;
                end
                cwbuf.push_back(bus.out_data);
                if (bus.out_parity) par_seen++;
                if (bus.out_eop) begin
                    eop_cyc  = cyc;
                    have_eop = 1'b1;
                    bad = 0;
                    for (int j = 0; j < 16; j++) begin
                        s = 8'h00;
                        foreach (cwbuf[k]) s = gmul(s, alog[j]) ^ cwbuf[k];
                        if (s != 8'h00) bad++;
                    end
                    chk("syndromes_zero", bad, 32'd0);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back('{d: bus.in_data, sop: (m_cnt == 0), eop: 1'b0, par: 1'b0});
                fb = bus.in_data ^ rem[15];
                for (int i = 15; i >= 1; i--) rem[i] = rem[i-1] ^ gmul(gen[i], fb);
                rem[0] = gmul(gen[0], fb);
                m_cnt++;
                if (bus.in_last || m_cnt == 239) begin
                    for (int j = 0; j < 16; j++)
                        sb.push_back('{d: rem[15-j], sop: 1'b0, eop: (j == 15), par: 1'b1});
                    for (int i = 0; i < 16; i++) rem[i] = 8'h00;
                    m_cnt   = 0;
                    exp_par = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        bit acc = 1'b0;
        int b   = 0;
        if (bp_mode)
            while ($urandom_range(0, 99) >= 70) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!acc && b < 1000) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            b++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("in_accept_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_msg(input int len);
        for (int i = 0; i < len; i++) send(msg[i], (i == len - 1));
    endtask

    task automatic wait_drain();
        int b = 0;
        while (sb.size() != 0 && b < 5000) begin
            @(posedge clk); #1;
            b++;
        end
        chk("drain_timeout", sb.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rand_msg(input int len);
        for (int i = 0; i < len; i++) msg[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        logic [7:0] gp [17];
        logic [7:0] x;
        logic [7:0] tmp [10];
        int         c0, bad, b;

        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            alog[i] = x;
            lg[x]   = i;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        alog[255] = 8'h01;
        lg[0]     = 0;
        for (int i = 0; i < 17; i++) gp[i] = 8'h00;
        gp[0] = 8'h01;
        for (int r = 0; r < 16; r++) begin
            for (int j = 16; j >= 1; j--) gp[j] = gp[j-1] ^ gmul(gp[j], alog[r]);
            gp[0] = gmul(gp[0], alog[r]);
        end
        for (int i = 0; i < 16; i++) gen[i] = gp[i];

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;

        // Reset state
        #1;
        chk("reset_outputs", {19'd0, bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop,
            bus.out_parity, bus.cw_done}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);
        chk("out_valid_after_reset", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk); #1;

        // All-zero full-length message
        for (int i = 0; i < 239; i++) msg[i] = 8'h00;
        cap.delete();
        c0 = cw_cnt;
        send_msg(239);
        wait_drain();
        chk("zero_len", cap.size(), 32'd255);
        chk("zero_sop_to_eop", eop_cyc - sop_cyc, 32'd254);
        bad = 0;
        for (int i = 0; i < cap.size(); i++) if (cap[i] != 8'h00) bad++;
        chk("zero_all_symbols", bad, 32'd0);
        chk("zero_cw_done_count", cw_cnt - c0, 32'd1);

        // Impulse message exposes g(x), followed back-to-back by a random codeword
        msg[238] = 8'h01;
        cap.delete();
        send_msg(239);
        rand_msg(239);
        send_msg(239);
        wait_drain();
        chk("b2b_len", cap.size(), 32'd510);
        for (int j = 0; j < 16; j++)
            chk($sformatf("impulse_parity_%0d", j), {24'd0, cap[239+j]}, {24'd0, gen[15-j]});
        chk("impulse_last_alpha120", {24'd0, cap[254]}, {24'd0, alog[120]});
        chk("b2b_eop_to_sop_gap", last_gap, 32'd1);

        // Shortened code: in_last on the 10th symbol
        rand_msg(10);
        for (int i = 0; i < 10; i++) tmp[i] = msg[i];
        cap.delete();
        send_msg(10);
        wait_drain();
        chk("short_len", cap.size(), 32'd26);
        for (int j = 0; j < 16; j++) p_short[j] = cap[10+j];
        for (int i = 0; i < 229; i++) msg[i] = 8'h00;
        for (int i = 0; i < 10; i++) msg[229+i] = tmp[i];
        cap.delete();
        send_msg(239);
        wait_drain();
        bad = 0;
        for (int j = 0; j < 16; j++) if (cap[239+j] != p_short[j]) bad++;
        chk("short_vs_padded_parity", bad, 32'd0);

        // Backpressure: same message with and without stalls
        rand_msg(60);
        cap.delete();
        send_msg(60);
        wait_drain();
        capa = cap;
        cap.delete();
        bp_mode = 1'b1;
        send_msg(60);
        wait_drain();
        bp_mode = 1'b0;
        @(posedge clk); #1;
        chk("bp_len", cap.size(), capa.size());
        bad = 0;
        for (int i = 0; i < capa.size() && i < cap.size(); i++) if (cap[i] != capa[i]) bad++;
        chk("bp_stream_identical", bad, 32'd0);

        // Reset during parity, then re-encode
        rand_msg(20);
        cap.delete();
        send_msg(20);
        wait_drain();
        capa = cap;
        send_msg(20);
        b = 0;
        while (par_seen < 5 && b < 500) begin
            @(posedge clk); #1;
            b++;
        end
        chk("reach_parity5_timeout", {31'd0, par_seen >= 5}, 32'd1);
        c0 = cw_cnt;
        reset = 1'b0;
        #1;
        chk("midcw_reset_outputs", {19'd0, bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop,
            bus.out_parity, bus.cw_done}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cap.delete();
        send_msg(20);
        wait_drain();
        chk("after_reset_cw_done_count", cw_cnt - c0, 32'd1);
        chk("after_reset_len", cap.size(), capa.size());
        bad = 0;
        for (int i = 0; i < capa.size() && i < cap.size(); i++) if (cap[i] != capa[i]) bad++;
        chk("after_reset_identical", bad, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete, observed time %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
